// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message queue front end.
// Contents: IV constant, register map, CTRL/STATUS bit positions,
// block/hash/tag types and the sequencer state encoding.
// No ports (package).
package sha256_pkg;

  typedef logic [15:0][31:0] blk_t;   // word 0 lives in [15] -> bits [511:480]
  typedef logic [7:0][31:0]  hash_t;  // H0 lives in [7]      -> bits [255:224]

  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} fsm_e;

  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  localparam hash_t SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam int NUM_BLK_WORDS = 16;
  localparam int REG_CTRL      = 16;
  localparam int REG_STATUS    = 17;
  localparam int REG_DIGEST0   = 18;
  localparam int NUM_DIGEST_W  = 8;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_FIRST  = 1;
  localparam int CTRL_LAST   = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int STATUS_DONE    = 0;
  localparam int STATUS_BUSY    = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_FULL    = 3;
  localparam int STATUS_EMPTY   = 4;
  localparam int STATUS_IRQ     = 5;
  localparam int STATUS_CNT_LSB = 8;

endpackage

// File: rtl/sha256_blk_ring.sv
// Ring of NUM_BUFS 512-bit message blocks with {FIRST,LAST} tags.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clear              drop all queued blocks (pointers, count, tags)
//   wr_en/wr_idx/wr_data  word write into the fill buffer buf[wr_ptr]
//   commit/commit_tag  tag the fill buffer and push it
//   pop                retire the block at rd_ptr
//   rd_blk/rd_tag      block and tag at rd_ptr
//   count/full/empty   occupancy
// Writes and commits arriving while full are dropped here; the caller
// flags the overflow.
module sha256_blk_ring
  import sha256_pkg::*;
#(
  parameter  int NUM_BUFS = 2,
  localparam int PTR_W    = $clog2(NUM_BUFS),
  localparam int CNT_W    = $clog2(NUM_BUFS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  input  tag_t             commit_tag,
  input  logic             pop,
  output blk_t             rd_blk,
  output tag_t             rd_tag,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  blk_t             bufs [NUM_BUFS];
  tag_t             tags [NUM_BUFS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             commit_ok;

  assign full      = (count == CNT_W'(NUM_BUFS));
  assign empty     = (count == '0);
  assign wr_ok     = wr_en & ~full;
  assign commit_ok = commit & ~full & ~clear;
  assign rd_blk    = bufs[rd_ptr];
  assign rd_tag    = tags[rd_ptr];

  // Word i is stored at packed index 15-i, which for 4 bits is ~i.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFS; i++) bufs[i] <= '0;
    end else if (wr_ok) begin
      bufs[wr_ptr][~wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_BUFS; i++) tags[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit_ok) begin
        tags[wr_ptr] <= commit_tag;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({commit_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha256_msg_queue_ctrl.sv
// Avalon-MM front end queueing message blocks for the SHA-256 core,
// chaining H across FIRST..LAST blocks and holding the final digest.
// Ports:
//   CLK, RESET                        clock, synchronous active-high reset
//   AVL_READ/WRITE/ADDR/WRITEDATA     Avalon-MM slave inputs
//   AVL_READDATA                      registered read data
//   core_start/core_block/core_hin    launch interface to the core
//   core_done/core_digest             result interface from the core
//   irq                               LAST-block completion interrupt
// Build option: define SHA256_MSGQ_IRQ_EN to enable the IRQ status bit
// and irq output; otherwise irq is tied low.
//
// state   | meaning
// IDLE    | waiting for a queued block
// START   | one-cycle core_start for buf[rd_ptr]
// WAIT    | core hashing, waiting for core_done
// CAPTURE | latch digest, retire block
module sha256_msg_queue_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_BUFS = 2,
  parameter int ADDR_W   = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic              core_start,
  output logic [511:0]      core_block,
  output logic [255:0]      core_hin,
  input  logic              core_done,
  input  logic [255:0]      core_digest,
  output logic              irq
);

  localparam int CNT_W = $clog2(NUM_BUFS + 1);

  fsm_e             state, state_nxt;
  hash_t            digest;
  logic             done_q, ovf_q, irq_q;
  logic             word_wr, ctrl_wr, stat_wr;
  logic             commit, abort, capture;
  tag_t             commit_tag, rd_tag;
  blk_t             rd_blk;
  logic [CNT_W-1:0] count;
  logic             full, empty, busy;
  logic [2:0]       dig_idx;
  logic [31:0]      status_word, rd_mux;

  assign word_wr    = AVL_WRITE && (AVL_ADDR < ADDR_W'(NUM_BLK_WORDS));
  assign ctrl_wr    = AVL_WRITE && (AVL_ADDR == ADDR_W'(REG_CTRL));
  assign stat_wr    = AVL_WRITE && (AVL_ADDR == ADDR_W'(REG_STATUS));
  assign abort      = ctrl_wr & AVL_WRITEDATA[CTRL_ABORT];
  assign commit     = ctrl_wr & AVL_WRITEDATA[CTRL_COMMIT];
  assign commit_tag = tag_t'{first: AVL_WRITEDATA[CTRL_FIRST], last: AVL_WRITEDATA[CTRL_LAST]};

  sha256_blk_ring #(.NUM_BUFS(NUM_BUFS)) u_ring (
    .clk        (CLK),
    .reset      (RESET),
    .clear      (abort),
    .wr_en      (word_wr),
    .wr_idx     (AVL_ADDR[3:0]),
    .wr_data    (AVL_WRITEDATA),
    .commit     (commit),
    .commit_tag (commit_tag),
    .pop        (capture),
    .rd_blk     (rd_blk),
    .rd_tag     (rd_tag),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Buffer at rd_ptr cannot be refilled while queued, and digest only moves
  // in CAPTURE, so both stay stable from START through core_done.
  assign core_block = rd_blk;
  assign core_hin   = rd_tag.first ? SHA256_IV : digest;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // core_done is only honoured in WAIT, so stale pulses after ABORT or
  // RESET fall through harmlessly.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    core_start = (state == START);
    capture    = (state == CAPTURE) && !abort;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      digest <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (capture) digest <= core_digest;

      if (capture)                                    done_q <= rd_tag.last;
      else if (core_start && rd_tag.first)            done_q <= 1'b0;
      else if (stat_wr && AVL_WRITEDATA[STATUS_DONE]) done_q <= 1'b0;

      // A fresh overflow wins over a same-cycle clear so it is never lost.
      if (full && (word_wr || commit))               ovf_q <= 1'b1;
      else if (stat_wr && AVL_WRITEDATA[STATUS_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef SHA256_MSGQ_IRQ_EN
  always_ff @(posedge CLK) begin
    if (RESET)                                     irq_q <= 1'b0;
    else if (capture && rd_tag.last)               irq_q <= 1'b1;
    else if (stat_wr && AVL_WRITEDATA[STATUS_IRQ]) irq_q <= 1'b0;
  end
`else
  assign irq_q = 1'b0;
`endif

  assign irq  = irq_q;
  assign busy = (state != IDLE) || !empty;

  // Digest word i sits at packed index 7-i, which for 3 bits is ~i.
  assign dig_idx = 3'(AVL_ADDR - ADDR_W'(REG_DIGEST0));

  always_comb begin
    status_word                         = '0;
    status_word[STATUS_DONE]            = done_q;
    status_word[STATUS_BUSY]            = busy;
    status_word[STATUS_OVF]             = ovf_q;
    status_word[STATUS_FULL]            = full;
    status_word[STATUS_EMPTY]           = empty;
    status_word[STATUS_IRQ]             = irq_q;
    status_word[STATUS_CNT_LSB +: 8]    = 8'(count);

    rd_mux = '0;
    if (AVL_ADDR == ADDR_W'(REG_STATUS))
      rd_mux = status_word;
    else if (AVL_ADDR >= ADDR_W'(REG_DIGEST0) &&
             AVL_ADDR <  ADDR_W'(REG_DIGEST0 + NUM_DIGEST_W))
      rd_mux = digest[~dig_idx];
  end

  always_ff @(posedge CLK) begin
    if (RESET)         AVL_READDATA <= '0;
    else if (AVL_READ) AVL_READDATA <= rd_mux;
  end

endmodule

// File: tb/tb_sha256_msg_queue_ctrl.sv
// Bench for sha256_msg_queue_ctrl with a behavioural SHA-256 core model.
module tb_sha256_msg_queue_ctrl;

  localparam int ADDR_W   = 5;
  localparam int CORE_LAT = 40;
  localparam int R_CTRL   = 16;
  localparam int R_STAT   = 17;
  localparam int R_DIG0   = 18;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              AVL_READ = 1'b0;
  logic              AVL_WRITE = 1'b0;
  logic [ADDR_W-1:0] AVL_ADDR = '0;
  logic [31:0]       AVL_WRITEDATA = '0;
  logic [31:0]       AVL_READDATA;
  logic              core_start;
  logic [511:0]      core_block;
  logic [255:0]      core_hin;
  logic              core_done = 1'b0;
  logic [255:0]      core_digest = '0;
  logic              irq;

  always #5 CLK = ~CLK;

  sha256_msg_queue_ctrl #(.NUM_BUFS(2), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
    .core_done(core_done), .core_digest(core_digest), .irq(irq));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Returns H_in + compression(H_in, blk), as the real core does.
  function automatic logic [255:0] sha_core(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Core model: latches on core_start, answers CORE_LAT cycles later
  // unless hold_done is set.
  logic         hold_done = 1'b0;
  int           start_cnt = 0;
  logic [255:0] last_hin = '0;
  logic [511:0] m_blk;
  logic [255:0] m_hin;
  logic         pending = 1'b0;
  int           lat = 0;

  always @(negedge CLK) begin
    core_done = 1'b0;
    if (core_start) begin
      start_cnt++;
      last_hin = core_hin;
      m_blk    = core_block;
      m_hin    = core_hin;
      pending  = 1'b1;
      lat      = CORE_LAT;
    end else if (pending) begin
      if (lat > 0) lat--;
      else if (!hold_done) begin
        core_done   = 1'b1;
        core_digest = sha_core(m_hin, m_blk);
        pending     = 1'b0;
      end
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    AVL_ADDR = ADDR_W'(a); AVL_WRITEDATA = d; AVL_WRITE = 1'b1;
    @(posedge CLK); #1;
    AVL_WRITE = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    AVL_ADDR = ADDR_W'(a); AVL_READ = 1'b1;
    @(posedge CLK); #1;
    AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic write_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) wr(i, blk[511-32*i -: 32]);
  endtask

  task automatic read_digest(output logic [255:0] dg);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(R_DIG0 + i, v);
      dg[255-32*i -: 32] = v;
    end
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    s = 32'h2;
    for (int i = 0; i < 2000 && s[1]; i++) rd(R_STAT, s);
    check(name, s[1], 1'b0);
  endtask

  typedef struct {
    string        name;
    int           addr;
    logic [31:0]  exp;
  } reg_vec_t;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic [31:0]  ctrl;
    logic [255:0] exp;
  } msg_vec_t;

  reg_vec_t     rv [6];
  msg_vec_t     mv [2];
  logic [511:0] blk1, blk2;
  logic [255:0] dg, two_blk_dg;
  logic [31:0]  s;
  int           s0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rv[0] = '{"rst_status",  R_STAT,   32'h0000_0010};
    rv[1] = '{"rst_dig0",    R_DIG0,   32'h0};
    rv[2] = '{"rst_dig7",    R_DIG0+7, 32'h0};
    rv[3] = '{"rd_ctrl",     R_CTRL,   32'h0};
    rv[4] = '{"rd_word0",    0,        32'h0};
    rv[5] = '{"rd_unmapped", 30,       32'h0};

    mv[0] = '{"hello_world",
              {32'h68656C6C, 32'h6F20776F, 32'h726C6480, 384'h0, 32'h00000058}, 32'h7,
              256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9};
    mv[1] = '{"abc",
              {32'h61626380, 448'h0, 32'h00000018}, 32'h7,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};

    blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk2 = {480'h0, 32'h000001c0};

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_core_start", core_start, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", AVL_READDATA, 32'h0);
    check("rst_core_block", core_block, 512'h0);
    check("rst_core_hin", core_hin, 256'h0);
    @(posedge CLK); #1;

    foreach (rv[i]) begin
      rd(rv[i].addr, s);
      check(rv[i].name, s, rv[i].exp);
    end

    foreach (mv[i]) begin
      write_block(mv[i].blk);
      wr(R_CTRL, mv[i].ctrl);
      wait_idle({mv[i].name, "_idle"});
      check({mv[i].name, "_hin_iv"}, last_hin, IV);
      rd(R_STAT, s);
      check({mv[i].name, "_status"}, s & ~32'h20, 32'h11);
      read_digest(dg);
      check({mv[i].name, "_digest"}, dg, mv[i].exp);
`ifdef SHA256_MSGQ_IRQ_EN
      check({mv[i].name, "_irq_set"}, {irq, s[5]}, 2'b11);
      wr(R_STAT, 32'h20);
      @(negedge CLK);
      check({mv[i].name, "_irq_clr"}, irq, 1'b0);
      @(posedge CLK); #1;
`else
      check({mv[i].name, "_irq_off"}, {irq, s[5]}, 2'b00);
`endif
    end

    // Two-block message, second block queued while the first hashes.
    s0 = start_cnt;
    write_block(blk1);
    wr(R_CTRL, 32'h3);
    write_block(blk2);
    wr(R_CTRL, 32'h5);
    wait_idle("two_blk_idle");
    check("two_blk_starts", 32'(start_cnt - s0), 32'd2);
    check("two_blk_chain_hin", last_hin, sha_core(IV, blk1));
    read_digest(two_blk_dg);
    check("two_blk_digest", two_blk_dg,
          256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    rd(R_STAT, s);
    check("two_blk_done", s[0], 1'b1);
    wr(R_STAT, 32'h20);

    // Overflow: core stalled, three untagged commits into a 2-deep ring.
    hold_done = 1'b1;
    s0 = start_cnt;
    write_block({16{32'h11111111}});
    wr(R_CTRL, 32'h1);
    write_block({16{32'h22222222}});
    wr(R_CTRL, 32'h1);
    write_block({16{32'h33333333}});
    wr(R_CTRL, 32'h1);
    rd(R_STAT, s);
    check("ovf_status", s & ~32'h20, 32'h0000_020F);
    check("ovf_one_start", 32'(start_cnt - s0), 32'd1);
    wr(R_STAT, 32'h4);
    rd(R_STAT, s);
    check("ovf_clear", s & ~32'h20, 32'h0000_020B);

    // Abort while the core is busy, then let the stale done arrive.
    wr(R_CTRL, 32'h8);
    rd(R_STAT, s);
    check("abort_status", s & ~32'h20, 32'h0000_0011);
    hold_done = 1'b0;
    repeat (CORE_LAT + 10) @(posedge CLK);
    #1;
    check("abort_no_start", 32'(start_cnt - s0), 32'd1);
    check("abort_late_done_ignored", pending, 1'b0);
    rd(R_STAT, s);
    check("abort_status_after", s & ~32'h20, 32'h0000_0011);
    read_digest(dg);
    check("abort_digest_kept", dg, two_blk_dg);
    check("final_irq", irq, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
